i2c_temp_datapath: RTL and testbench

- Datapath stage that sits directly beside the I2C read-temperature controller FSM.
- Generates the I2C serial clock `ClockI2C` that the controller consumes.
- Executes the controller's control strobes (`WriteLoad`, `ShiftorHold`, `Select`, `ReadOrWrite`, `StartStopAck`):
  - shifts out the TMP101 address byte;
  - drives or releases SDA;
  - shifts in the temperature byte;
  - captures the slave address ACK.
- On `Done` it publishes the 8-bit temperature (integer °C, TMP101 MSB byte) with a one-cycle valid pulse.

---
 rtl/i2c_temp_datapath_pkg.sv | 14 +
 rtl/i2c_temp_datapath_if.sv | 34 +++
 rtl/i2c_temp_datapath_baud_gen.sv | 39 +++
 rtl/i2c_temp_datapath.sv | 107 ++++++++++
 tb/tb_i2c_temp_datapath.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_temp_datapath_pkg.sv
// Shared constants and helpers for the TMP101 read-temperature datapath.
package i2c_pkg;

  localparam logic [6:0] TMP101_ADDR = 7'b1001000;
  localparam logic       I2C_READ    = 1'b1;
  localparam int         BYTE_W      = 8;
  localparam int         BAUD_W      = 11;

  // Number of system clocks per SCL half period, minus one (terminal count).
  function automatic int baud_half(input int clock_hz, input int i2c_hz);
    return clock_hz / (2 * i2c_hz) - 1;
  endfunction

endpackage

// File: rtl/i2c_temp_datapath_if.sv
// Control strobes from the I2C controller and the datapath's bus-side results.
interface i2c_temp_datapath_if;
  import i2c_pkg::*;

  logic              BaudEnable;
  logic              WriteLoad;
  logic              Select;
  logic              ReadOrWrite;
  logic              ShiftorHold;
  logic              StartStopAck;
  logic              Done;
  logic              SDA_in;
  logic              ClockI2C;
  logic              SDA_out;
  logic              SDA_oe;
  logic [BYTE_W-1:0] Temperature;
  logic              TempValid;
  logic              AckError;

  // Controller side: issues strobes and presents the synchronized SDA pad.
  modport master (
    output BaudEnable, WriteLoad, Select, ReadOrWrite, ShiftorHold,
           StartStopAck, Done, SDA_in,
    input  ClockI2C, SDA_out, SDA_oe, Temperature, TempValid, AckError
  );

  // Datapath side: executes the strobes and reports results.
  modport slave (
    input  BaudEnable, WriteLoad, Select, ReadOrWrite, ShiftorHold,
           StartStopAck, Done, SDA_in,
    output ClockI2C, SDA_out, SDA_oe, Temperature, TempValid, AckError
  );

endinterface

// File: rtl/i2c_temp_datapath_baud_gen.sv
// SCL generator: toggles every HALF+1 enabled cycles, idles high when disabled.
module i2c_baud_gen
  import i2c_pkg::*;
#(
  parameter int HALF = 499
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic scl,
  output logic scl_rise
);

  logic [BAUD_W-1:0] count;
  logic              at_half;

  assign at_half = (count == BAUD_W'(HALF));

  // Half-period counter and SCL toggle; disabling parks the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      scl      <= 1'b1;
      scl_rise <= 1'b0;
    end else if (!en) begin
      count    <= '0;
      scl      <= 1'b1;
      scl_rise <= 1'b0;
    end else if (at_half) begin
      count    <= '0;
      scl      <= ~scl;
      scl_rise <= ~scl;
    end else begin
      count    <= count + 1'b1;
      scl_rise <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_temp_datapath.sv
// TMP101 read datapath: SCL generation, address shift-out, byte shift-in,
// address ACK capture and temperature publication on Done.
module i2c_temp_datapath
  import i2c_pkg::*;
#(
  parameter int         CLOCK_HZ   = 100000000,
  parameter int         I2C_HZ     = 100000,
  parameter logic [6:0] SLAVE_ADDR = TMP101_ADDR
) (
  input logic                clock,
  input logic                Reset,
  i2c_temp_datapath_if.slave bus
);

  localparam int HALF = baud_half(CLOCK_HZ, I2C_HZ);

  logic [BYTE_W-1:0] tx_reg;
  logic [BYTE_W-1:0] rx_reg;
  logic [3:0]        rx_count;
  logic              done_q;
  logic              scl_rise;
  logic              tx_shift;
  logic              rx_shift;
  logic              ack_slot;
  logic              done_rise;
  logic              rx_full;

  assign rx_full   = (rx_count == 4'(BYTE_W));
  assign tx_shift  = bus.ShiftorHold && bus.Select && !bus.ReadOrWrite;
  assign rx_shift  = bus.ShiftorHold && bus.Select && bus.ReadOrWrite && !rx_full;
  assign ack_slot  = scl_rise && bus.ReadOrWrite && !bus.Select && (rx_count == 4'd0);
  assign done_rise = bus.Done && !done_q;

  i2c_baud_gen #(.HALF(HALF)) u_baud (
    .clk      (clock),
    .rst      (Reset),
    .en       (bus.BaudEnable),
    .scl      (bus.ClockI2C),
    .scl_rise (scl_rise)
  );

  // Address byte register; a load beats a shift in the same cycle.
  always_ff @(posedge clock) begin
    if (Reset)
      tx_reg <= '0;
    else if (bus.WriteLoad)
      tx_reg <= {SLAVE_ADDR, I2C_READ};
    else if (tx_shift)
      tx_reg <= {tx_reg[BYTE_W-2:0], 1'b0};
  end

  // Registered SDA drive: release for reads, else data bit or start/stop/ack level.
  always_ff @(posedge clock) begin
    if (Reset) begin
      bus.SDA_out <= 1'b1;
      bus.SDA_oe  <= 1'b1;
    end else if (bus.ReadOrWrite) begin
      bus.SDA_out <= 1'b1;
      bus.SDA_oe  <= 1'b0;
    end else begin
      bus.SDA_oe  <= 1'b1;
      bus.SDA_out <= bus.Select ? tx_reg[BYTE_W-1] : bus.StartStopAck;
    end
  end

  // Received byte and bit count; count saturates at a full byte.
  always_ff @(posedge clock) begin
    if (Reset) begin
      rx_reg   <= '0;
      rx_count <= '0;
    end else begin
      if (rx_shift)
        rx_reg <= {rx_reg[BYTE_W-2:0], bus.SDA_in};
      if (bus.WriteLoad || done_rise)
        rx_count <= '0;
      else if (rx_shift)
        rx_count <= rx_count + 1'b1;
    end
  end

  // Sticky address NACK flag, cleared when a new transaction loads the address.
  always_ff @(posedge clock) begin
    if (Reset)
      bus.AckError <= 1'b0;
    else if (bus.WriteLoad)
      bus.AckError <= 1'b0;
    else if (ack_slot)
      bus.AckError <= bus.SDA_in;
  end

  // Publish a complete, acknowledged byte once per rising edge of Done.
  always_ff @(posedge clock) begin
    if (Reset) begin
      done_q          <= 1'b0;
      bus.Temperature <= '0;
      bus.TempValid   <= 1'b0;
    end else begin
      done_q        <= bus.Done;
      bus.TempValid <= 1'b0;
      if (done_rise && rx_full && !bus.AckError) begin
        bus.Temperature <= rx_reg;
        bus.TempValid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_temp_datapath.sv
// Self-checking bench for i2c_temp_datapath: directed baud/shift/ACK steps
// followed by randomized read transactions against a byte-level model.
module tb_i2c_temp_datapath;
  import i2c_pkg::*;

  logic       clock = 1'b0;
  logic       Reset;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_temp;

  i2c_temp_datapath_if bus ();

  i2c_temp_datapath dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic controls_idle();
    bus.BaudEnable   = 1'b0;
    bus.WriteLoad    = 1'b0;
    bus.Select       = 1'b0;
    bus.ReadOrWrite  = 1'b0;
    bus.ShiftorHold  = 1'b0;
    bus.StartStopAck = 1'b1;
    bus.Done         = 1'b0;
    bus.SDA_in       = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scl"},  32'(bus.ClockI2C),    32'd1);
    check({tag, "_sda"},  32'(bus.SDA_out),     32'd1);
    check({tag, "_oe"},   32'(bus.SDA_oe),      32'd1);
    check({tag, "_temp"}, 32'(bus.Temperature), 32'd0);
    check({tag, "_vld"},  32'(bus.TempValid),   32'd0);
    check({tag, "_ack"},  32'(bus.AckError),    32'd0);
  endtask

  task automatic load_addr();
    bus.WriteLoad = 1'b1;
    step(1);
    bus.WriteLoad = 1'b0;
  endtask

  // Wait for the next SCL low-to-high transition, bounded.
  task automatic wait_scl_rise(input string tag);
    int n = 0;
    while (bus.ClockI2C !== 1'b0 && n < 1100) begin step(1); n++; end
    while (bus.ClockI2C !== 1'b1 && n < 2200) begin step(1); n++; end
    check(tag, 32'(n < 2200), 32'd1);
  endtask

  // Present bits of b MSB first on SDA_in, one read shift strobe each.
  task automatic read_bits(input logic [7:0] b, input int n);
    bus.Select      = 1'b1;
    bus.ReadOrWrite = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.SDA_in      = (i < 8) ? b[7-i] : 1'($urandom);
      bus.ShiftorHold = 1'b1;
      step(1);
      bus.ShiftorHold = 1'b0;
      step(1);
    end
  endtask

  task automatic finish_read(input string tag, input logic exp_pulse);
    bus.Select = 1'b0;
    bus.Done   = 1'b1;
    step(1);
    check({tag, "_valid"},  32'(bus.TempValid),   32'(exp_pulse));
    check({tag, "_temp"},   32'(bus.Temperature), 32'(exp_temp));
    step(1);
    check({tag, "_single"}, 32'(bus.TempValid),   32'd0);
    step(1);
    bus.Done = 1'b0;
    step(1);
    check({tag, "_rxcnt"},  32'(dut.rx_count),    32'd0);
  endtask

  task automatic ack_slot(input logic sda, input logic exp_err, input string tag);
    bus.Select      = 1'b0;
    bus.ReadOrWrite = 1'b1;
    bus.SDA_in      = sda;
    bus.BaudEnable  = 1'b1;
    step(1);
    check({tag, "_oe"}, 32'(bus.SDA_oe), 32'd0);
    wait_scl_rise({tag, "_rise"});
    step(2);
    bus.BaudEnable = 1'b0;
    check({tag, "_err"}, 32'(bus.AckError), 32'(exp_err));
  endtask

  initial begin
    int         n;
    int         lens[4] = '{5, 8, 8, 9};
    logic [7:0] addr_byte;
    logic [7:0] b;
    logic       nack;
    logic       pulse;

    addr_byte = {7'b1001000, 1'b1};
    exp_temp  = 8'h00;
    controls_idle();
    Reset = 1'b1;
    step(2);
    check_reset_outputs("reset");
    Reset = 1'b0;

    // Baud timing: first fall after 500 enabled cycles, then 500/500.
    bus.BaudEnable = 1'b1;
    n = 0;
    while (bus.ClockI2C === 1'b1 && n < 2000) begin step(1); n++; end
    check("baud_first_fall", 32'(n), 32'd500);
    n = 0;
    while (bus.ClockI2C === 1'b0 && n < 2000) begin step(1); n++; end
    check("baud_low_phase", 32'(n), 32'd500);
    while (bus.ClockI2C === 1'b1 && n < 2000) begin step(1); n++; end
    check("baud_period", 32'(n), 32'd1000);
    bus.BaudEnable = 1'b0;
    step(1);
    check("baud_idle_high", 32'(bus.ClockI2C), 32'd1);

    // Address shift-out: SDA_out walks 0x91 MSB first.
    load_addr();
    bus.Select      = 1'b1;
    bus.ReadOrWrite = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.ShiftorHold = 1'b1;
      step(1);
      check($sformatf("addr_bit%0d", k), 32'(bus.SDA_out), 32'(addr_byte[7-k]));
      check($sformatf("addr_oe%0d", k),  32'(bus.SDA_oe),  32'd1);
      bus.ShiftorHold = 1'b0;
      step(1);
    end
    check("addr_drained", 32'(dut.tx_reg), 32'd0);

    // Load beats shift in the same cycle.
    bus.WriteLoad   = 1'b1;
    bus.ShiftorHold = 1'b1;
    step(1);
    bus.WriteLoad   = 1'b0;
    bus.ShiftorHold = 1'b0;
    check("load_priority", 32'(dut.tx_reg), 32'(addr_byte));

    // Address ACK slot: ACK then NACK.
    load_addr();
    ack_slot(1'b0, 1'b0, "ack_ok");
    ack_slot(1'b1, 1'b1, "ack_nack");

    // Full byte after a NACKed address is discarded.
    read_bits(8'h19, 8);
    finish_read("nack_read", 1'b0);

    // Good read of 0x19.
    load_addr();
    check("ack_cleared", 32'(bus.AckError), 32'd0);
    read_bits(8'h19, 8);
    exp_temp = 8'h19;
    finish_read("read19", 1'b1);

    // Short read: only 5 bits, temperature holds.
    load_addr();
    read_bits(8'hA5, 5);
    finish_read("short_read", 1'b0);

    // Randomized transactions against the byte-level model.
    for (int t = 0; t < 8; t++) begin
      b    = 8'($urandom);
      n    = lens[$urandom_range(0, 3)];
      nack = ($urandom_range(0, 3) == 0);
      load_addr();
      if (nack) ack_slot(1'b1, 1'b1, $sformatf("rnd%0d_ack", t));
      read_bits(b, n);
      if (n > 8) begin
        check($sformatf("rnd%0d_sat_cnt", t),  32'(dut.rx_count), 32'd8);
        check($sformatf("rnd%0d_sat_data", t), 32'(dut.rx_reg),   32'(b));
      end
      pulse = (n >= 8) && !nack;
      if (pulse) exp_temp = b;
      finish_read($sformatf("rnd%0d", t), pulse);
    end

    // Reset in the middle of a read with SCL low.
    load_addr();
    bus.BaudEnable = 1'b1;
    read_bits(8'hC3, 3);
    step(520);
    check("midread_scl_low", 32'(bus.ClockI2C), 32'd0);
    Reset = 1'b1;
    step(1);
    check_reset_outputs("midread_reset");
    check("midread_rxcnt", 32'(dut.rx_count), 32'd0);
    Reset = 1'b0;
    controls_idle();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
